spi_slave_reg_ctrl: RTL and testbench

Frame-level controller for the byte-wide full-duplex SPI slave driver. It interprets each byte from the driver as part of a command/data frame, performs auto-incrementing writes and reads on a register bank, and supplies the driver's response byte. It sits between the driver (`rec_data`/`rec_done`/`response_data`) and the user register file.

---
 rtl/spi_slave_reg_ctrl_pkg.sv | 18 +
 rtl/spi_slave_reg_ctrl_if.sv | 28 ++
 rtl/spi_slave_reg_ctrl_sync_2ff.sv | 26 ++
 rtl/spi_slave_reg_ctrl.sv | 133 +++++++++++++
 tb/tb_spi_slave_reg_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_reg_ctrl_pkg.sv
// Shared types and constants for the SPI slave register controller.
// Holds the frame FSM encoding and the command-byte opcode field.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StRdFetch,
    StRdWait,
    StRdData,
    StWrData
  } state_e;

  localparam int unsigned OP_BIT   = 7;
  localparam logic        OP_WRITE = 1'b1;
  localparam logic        OP_READ  = 1'b0;

endpackage

// File: rtl/spi_slave_reg_ctrl_if.sv
// Byte-level driver link plus register-bank port of the SPI slave controller.
interface spi_slave_reg_ctrl_if #(
  parameter int unsigned ADDR_W = 7
);

  logic              cs_n;
  logic [7:0]        rec_data;
  logic              rec_done;
  logic [7:0]        response_data;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              frame_done;
  logic              busy;

  modport slave (
    input  cs_n, rec_data, rec_done, reg_rdata,
    output response_data, reg_addr, reg_wdata, reg_we, reg_re, frame_done, busy
  );

  modport master (
    output cs_n, rec_data, rec_done, reg_rdata,
    input  response_data, reg_addr, reg_wdata, reg_we, reg_re, frame_done, busy
  );

endinterface

// File: rtl/spi_slave_reg_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// Frame-level SPI slave controller: command byte then auto-incrementing register
// writes or prefetched reads, and the response byte for the byte-wide driver.
module spi_slave_reg_ctrl
  import spi_slave_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input logic                  clk,
  input logic                  rst,
  spi_slave_reg_ctrl_if.slave  bus
);

  logic              w_cs_n_sync;
  logic              r_cs_n_prev;
  logic              w_cs_fall;
  logic              w_cs_rise;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_resp, w_resp_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic              r_we, w_we_nxt;
  logic              r_re, w_re_nxt;
  logic              r_fd, w_fd_nxt;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.cs_n),
    .o_q (w_cs_n_sync)
  );

  assign w_cs_fall = r_cs_n_prev & ~w_cs_n_sync;
  assign w_cs_rise = ~r_cs_n_prev & w_cs_n_sync;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_resp_nxt  = r_resp;
    w_wdata_nxt = r_wdata;
    w_we_nxt    = 1'b0;
    w_fd_nxt    = 1'b0;

    // Address advances the cycle after each write strobe.
    if (r_we) begin
      w_addr_nxt = r_addr + 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        w_resp_nxt = STATUS_BYTE;
        if (w_cs_fall) begin
          w_state_nxt = StCmd;
        end
      end
      StCmd: begin
        if (bus.rec_done) begin
          w_addr_nxt = bus.rec_data[ADDR_W-1:0];
          if (bus.rec_data[OP_BIT] == OP_WRITE) begin
            w_state_nxt = StWrData;
            w_resp_nxt  = bus.rec_data;
          end else begin
            w_state_nxt = StRdFetch;
          end
        end
      end
      StRdFetch: begin
        w_state_nxt = StRdWait;
      end
      StRdWait: begin
        w_resp_nxt  = bus.reg_rdata;
        w_addr_nxt  = r_addr + 1'b1;
        w_state_nxt = StRdData;
      end
      StRdData: begin
        if (bus.rec_done) begin
          w_state_nxt = StRdFetch;
        end
      end
      StWrData: begin
        if (bus.rec_done) begin
          w_we_nxt    = 1'b1;
          w_wdata_nxt = bus.rec_data;
          w_resp_nxt  = bus.rec_data;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // End of frame wins over everything except a write already strobed above.
    if (w_cs_rise) begin
      w_state_nxt = StIdle;
      w_resp_nxt  = STATUS_BYTE;
      w_fd_nxt    = 1'b1;
    end

    w_re_nxt = (w_state_nxt == StRdFetch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cs_n_prev <= 1'b1;
      r_addr      <= '0;
      r_resp      <= STATUS_BYTE;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_fd        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cs_n_prev <= w_cs_n_sync;
      r_addr      <= w_addr_nxt;
      r_resp      <= w_resp_nxt;
      r_wdata     <= w_wdata_nxt;
      r_we        <= w_we_nxt;
      r_re        <= w_re_nxt;
      r_fd        <= w_fd_nxt;
    end
  end

  assign bus.response_data = r_resp;
  assign bus.reg_addr      = r_addr;
  assign bus.reg_wdata     = r_wdata;
  assign bus.reg_we        = r_we;
  assign bus.reg_re        = r_re;
  assign bus.frame_done    = r_fd;
  assign bus.busy          = (r_state != StIdle);

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Self-checking bench: emulates the byte driver and register bank, and compares
// MISO bytes and bank accesses against a frame-level reference model.
module tb_spi_slave_reg_ctrl;

  localparam int unsigned AW     = 3;
  localparam int unsigned NREG   = 1 << AW;
  localparam logic [7:0]  STATUS = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_reg_ctrl_if #(.ADDR_W(AW)) bus ();

  spi_slave_reg_ctrl #(
    .ADDR_W      (AW),
    .STATUS_BYTE (STATUS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register bank with one-cycle read latency.
  logic [7:0] rf [NREG];
  logic [7:0] rdata_q = 8'h00;
  always @(posedge clk) begin
    if (bus.reg_we) rf[bus.reg_addr] <= bus.reg_wdata;
    if (bus.reg_re) rdata_q <= rf[bus.reg_addr];
  end
  assign bus.reg_rdata = rdata_q;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_we) wr_q.push_back({8'(bus.reg_addr), bus.reg_wdata});
      if (bus.reg_re) rd_q.push_back(8'(bus.reg_addr));
      if (bus.frame_done) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] model_mem [NREG];
  logic [7:0] tx_q[$];

  // One byte on the wire: MISO is sampled at the first SCLK edge, then must hold.
  task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
    repeat (4) @(negedge clk);
    miso = bus.response_data;
    repeat (28) @(negedge clk);
    check("miso_stable", bus.response_data, miso);
    bus.rec_data = mosi;
    bus.rec_done = 1'b1;
    @(negedge clk);
    bus.rec_done = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_resp"}, bus.response_data, STATUS);
    check({tag, "_addr"}, bus.reg_addr, 0);
    check({tag, "_wdata"}, bus.reg_wdata, 0);
    check({tag, "_we"}, bus.reg_we, 0);
    check({tag, "_re"}, bus.reg_re, 0);
    check({tag, "_fdone"}, bus.frame_done, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic run_frame(input logic [7:0] cmd);
    logic [7:0]  miso;
    logic [7:0]  exp_miso;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int          fd0;
    int          n;
    int          start;
    bit          is_wr;
    n     = tx_q.size();
    is_wr = cmd[7];
    start = int'(cmd[AW-1:0]);
    wr_q.delete();
    rd_q.delete();
    fd0 = fd_cnt;
    @(negedge clk);
    bus.cs_n = 1'b0;
    xfer(cmd, miso);
    check("miso_cmd", miso, STATUS);
    for (int k = 0; k < n; k++) begin
      if (is_wr) exp_miso = (k == 0) ? cmd : tx_q[k-1];
      else       exp_miso = model_mem[(start + k) % NREG];
      xfer(tx_q[k], miso);
      check("miso_data", miso, exp_miso);
    end
    repeat (8) @(negedge clk);
    check("busy_in_frame", bus.busy, 1);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
    if (is_wr) begin
      for (int i = 0; i < n; i++) begin
        exp_wr.push_back({8'((start + i) % NREG), tx_q[i]});
        model_mem[(start + i) % NREG] = tx_q[i];
      end
    end else begin
      for (int i = 0; i <= n; i++) exp_rd.push_back(8'((start + i) % NREG));
    end
    check("wr_count", wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      if (i < wr_q.size()) check("wr_entry", wr_q[i], exp_wr[i]);
    check("rd_count", rd_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      if (i < rd_q.size()) check("rd_addr", rd_q[i], exp_rd[i]);
    check("frame_done_cnt", fd_cnt - fd0, 1);
    check("end_resp", bus.response_data, STATUS);
    check("end_busy", bus.busy, 0);
  endtask

  initial begin
    logic [7:0] miso;
    logic [7:0] cmd;
    int         n;
    int         fd0;

    bus.cs_n     = 1'b1;
    bus.rec_done = 1'b0;
    bus.rec_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Fill every register so later reads have known contents.
    tx_q.delete();
    for (int i = 0; i < NREG; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    run_frame(8'h80);

    tx_q = '{8'h11, 8'h22};
    run_frame(8'h85);
    tx_q = '{8'h3C, 8'h4D};
    run_frame(8'h83);
    tx_q = '{8'h00, 8'h00};
    run_frame(8'h03);
    tx_q = '{8'hC1, 8'hC2, 8'hC3};
    run_frame(8'h87);
    tx_q.delete();
    run_frame(8'h80);

    // Abort half-way into the first data byte.
    wr_q.delete();
    fd0 = fd_cnt;
    @(negedge clk);
    bus.cs_n = 1'b0;
    xfer(8'h81, miso);
    check("abort_miso_cmd", miso, STATUS);
    repeat (16) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_we", wr_q.size(), 0);
    check("abort_fdone", fd_cnt - fd0, 1);
    check("abort_resp", bus.response_data, STATUS);

    // Reset while the first read fetch is waiting on bank data.
    @(negedge clk);
    bus.cs_n = 1'b0;
    xfer(8'h02, miso);
    check("pre_rst_re", bus.reg_re, 1);
    @(negedge clk);
    rst      = 1'b1;
    bus.cs_n = 1'b1;
    #1;
    check_idle("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tx_q = '{8'h00, 8'h00};
    run_frame(8'h06);

    repeat (20) begin
      cmd = 8'($urandom_range(0, 255));
      n   = cmd[7] ? $urandom_range(0, 5) : $urandom_range(1, 5);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      run_frame(cmd);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
